// File: rtl/booth_mult_seq_if.sv
// rtl/booth_mult_seq_if.sv - start/busy/done handshake bundle for booth_mult_seq
// op_signed exists only when BOOTH_UNSIGNED_EN is defined.
interface booth_mult_seq_if #(
    parameter int WIDTH = 8
);
    logic                   start;
    logic [WIDTH-1:0]       multiplicand;
    logic [WIDTH-1:0]       multiplier;
`ifdef BOOTH_UNSIGNED_EN
    logic                   op_signed;
`endif
    logic                   busy;
    logic                   done;
    logic [2*WIDTH-1:0]     product;

    modport master (
`ifdef BOOTH_UNSIGNED_EN
        output op_signed,
`endif
        output start, multiplicand, multiplier,
        input  busy, done, product
    );

    modport slave (
`ifdef BOOTH_UNSIGNED_EN
        input  op_signed,
`endif
        input  start, multiplicand, multiplier,
        output busy, done, product
    );
endinterface

// File: rtl/booth_mult_seq.sv
// rtl/booth_mult_seq.sv - sequential radix-2 Booth multiplier, one iteration per clock
// BOOTH_UNSIGNED_EN adds op_signed and one extra iteration for unsigned operands.
module booth_mult_seq #(
    parameter int WIDTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    booth_mult_seq_if.slave   bus
);

`ifdef BOOTH_UNSIGNED_EN
    localparam int QW = WIDTH + 1;
`else
    localparam int QW = WIDTH;
`endif
    localparam int CW = $clog2(WIDTH + 2);
    localparam logic [CW-1:0] CNT_LOAD = CW'(QW);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [WIDTH:0]       a_q, a_d;
    logic [WIDTH:0]       m_q, m_d;
    logic [QW-1:0]        q_q, q_d;
    logic                 qm1_q, qm1_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   product_q, product_d;
    logic [WIDTH:0]       a_sel;
    logic [WIDTH:0]       m_ext;
    logic [QW-1:0]        q_ext;
    logic                 busy;
    logic                 done;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            a_q       <= '0;
            m_q       <= '0;
            q_q       <= '0;
            qm1_q     <= 1'b0;
            cnt_q     <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            m_q       <= m_d;
            q_q       <= q_d;
            qm1_q     <= qm1_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (bus.start) state_d = S_RUN;
            S_RUN:   if (cnt_q == CNT_ONE) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q != S_IDLE);
        done = (state_q == S_DONE);
    end

    assign bus.busy    = busy;
    assign bus.done    = done;
    assign bus.product = product_q;

    // Operand extension: the guard bit keeps -2^(WIDTH-1) representable after negation.
    always_comb begin
`ifdef BOOTH_UNSIGNED_EN
        m_ext = {bus.op_signed & bus.multiplicand[WIDTH-1], bus.multiplicand};
        q_ext = {bus.op_signed & bus.multiplier[WIDTH-1], bus.multiplier};
`else
        m_ext = {bus.multiplicand[WIDTH-1], bus.multiplicand};
        q_ext = bus.multiplier;
`endif
    end

    always_comb begin
        case ({q_q[0], qm1_q})
            2'b01:   a_sel = a_q + m_q;
            2'b10:   a_sel = a_q - m_q;
            default: a_sel = a_q;
        endcase
    end

    always_comb begin
        a_d       = a_q;
        m_d       = m_q;
        q_d       = q_q;
        qm1_d     = qm1_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    a_d   = '0;
                    m_d   = m_ext;
                    q_d   = q_ext;
                    qm1_d = 1'b0;
                    cnt_d = CNT_LOAD;
                end
            end
            S_RUN: begin
                {a_d, q_d, qm1_d} = {a_sel[WIDTH], a_sel, q_q};
                cnt_d = cnt_q - CNT_ONE;
            end
            S_DONE: begin
`ifdef BOOTH_UNSIGNED_EN
                product_d = {a_q[WIDTH-2:0], q_q};
`else
                product_d = {a_q[WIDTH-1:0], q_q};
`endif
            end
            default: begin
                a_d = a_q;
            end
        endcase
    end

endmodule

// File: tb/tb_booth_mult_seq.sv
// tb/tb_booth_mult_seq.sv - scoreboard bench for booth_mult_seq
module tb_booth_mult_seq;
    localparam int W = 8;
`ifdef BOOTH_UNSIGNED_EN
    localparam int LAT = W + 1;
`else
    localparam int LAT = W;
`endif
    localparam int EXP_BUSY = LAT + 1;
    localparam int PERIOD   = LAT + 2;

    typedef struct {
        logic [2*W-1:0] prod;
        int             cyc;
    } exp_t;

    typedef struct {
        logic [W-1:0]   m;
        logic [W-1:0]   q;
        logic           s;
        logic [2*W-1:0] p;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];
    int   done_times[$];

    booth_mult_seq_if #(.WIDTH(W)) bus ();

    booth_mult_seq #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    int   busy_cnt = 0;
    bit   done_seen = 0;
    bit   prev_busy = 0;
    exp_t cur;

    always @(negedge clk) begin
        if (rst) begin
            busy_cnt  = 0;
            done_seen = 0;
            prev_busy = 0;
        end else begin
            if (bus.busy) busy_cnt++;
            if (bus.done) begin
                done_times.push_back(cyc);
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_done: done high with empty scoreboard at cycle %0d", cyc);
                end else begin
                    cur = sb.pop_front();
                    check("done_cycle", cyc, cur.cyc);
                    done_seen = 1;
                end
            end
            if (prev_busy && !bus.busy) begin
                if (done_seen) begin
                    check("product", bus.product, cur.prod);
                    check("busy_cycles", busy_cnt, EXP_BUSY);
                end
                busy_cnt  = 0;
                done_seen = 0;
            end
            prev_busy = bus.busy;
        end
    end

    task automatic drive_ops(input logic [W-1:0] m, input logic [W-1:0] q, input logic s);
        bus.multiplicand = m;
        bus.multiplier   = q;
`ifdef BOOTH_UNSIGNED_EN
        bus.op_signed    = s;
`else
        if (s) bus.multiplier = q;
`endif
    endtask

    task automatic wait_idle();
        int g = 0;
        while (bus.busy && g < 200) begin
            @(posedge clk);
            #1;
            g++;
        end
        if (g >= 200) begin
            checks++;
            errors++;
            $display("FAIL wait_idle: busy stuck high at cycle %0d", cyc);
        end
    endtask

    task automatic issue(input vec_t v);
        wait_idle();
        drive_ops(v.m, v.q, v.s);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        sb.push_back('{prod: v.p, cyc: cyc + LAT});
        bus.start = 1'b0;
        drive_ops(W'($urandom), W'($urandom), 1'b1);
    endtask

    vec_t dir [0:6] = '{
        '{m: 8'h03, q: 8'h05, s: 1'b1, p: 16'h000F},
        '{m: 8'hF9, q: 8'h06, s: 1'b1, p: 16'hFFD6},
        '{m: 8'h06, q: 8'hF9, s: 1'b1, p: 16'hFFD6},
        '{m: 8'h80, q: 8'h80, s: 1'b1, p: 16'h4000},
        '{m: 8'h80, q: 8'h7F, s: 1'b1, p: 16'hC080},
        '{m: 8'hFF, q: 8'hFF, s: 1'b1, p: 16'h0001},
        '{m: 8'h7F, q: 8'h7F, s: 1'b1, p: 16'h3F01}
    };

    vec_t b2b [0:2] = '{
        '{m: 8'h12, q: 8'h34, s: 1'b1, p: 16'h03A8},
        '{m: 8'hFE, q: 8'h05, s: 1'b1, p: 16'hFFF6},
        '{m: 8'h7F, q: 8'h81, s: 1'b1, p: 16'hC0FF}
    };

    vec_t after_abort = '{m: 8'h0B, q: 8'hF3, s: 1'b1, p: 16'hFF71};

    initial begin
        int n;
        bus.start = 1'b0;
        drive_ops('0, '0, 1'b1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_busy", bus.busy, 0);
        check("reset_done", bus.done, 0);
        check("reset_product", bus.product, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        foreach (dir[i]) issue(dir[i]);

        // Abort: rst sampled at edge k+4 of an operation.
        wait_idle();
        drive_ops(8'h55, 8'h33, 1'b1);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort_busy", bus.busy, 0);
        check("abort_done", bus.done, 0);
        check("abort_product", bus.product, 0);
        @(posedge clk);
        #1;
        issue(after_abort);

        // Back-to-back: start held high, operands change every cycle.
        wait_idle();
        for (int t = 0; t < 3 * PERIOD; t++) begin
            if (t % PERIOD == 0)
                drive_ops(b2b[t / PERIOD].m, b2b[t / PERIOD].q, 1'b1);
            else
                drive_ops(W'($urandom), W'($urandom), 1'b1);
            bus.start = 1'b1;
            @(posedge clk);
            #1;
            if (t % PERIOD == 0)
                sb.push_back('{prod: b2b[t / PERIOD].p, cyc: cyc + LAT});
        end
        bus.start = 1'b0;
        wait_idle();
        n = done_times.size();
        if (n >= 3) begin
            check("done_spacing_a", done_times[n-1] - done_times[n-2], PERIOD);
            check("done_spacing_b", done_times[n-2] - done_times[n-3], PERIOD);
        end else begin
            checks++;
            errors++;
            $display("FAIL done_count: got %0d done pulses, required at least 3", n);
        end

`ifdef BOOTH_UNSIGNED_EN
        issue('{m: 8'hFF, q: 8'hFF, s: 1'b0, p: 16'hFE01});
        issue('{m: 8'hFF, q: 8'hFF, s: 1'b1, p: 16'h0001});
`endif

        wait_idle();
        repeat (2) @(negedge clk);
        check("scoreboard_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1);
    end
endmodule
